// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the instruction-memory loader and the
// program counter.
//   loader_state_t : loader FSM encoding (IDLE, LOAD, WRITE, DONE)
//   INST_W         : instruction width in bits
//   IMEM_BASE      : first instruction address; also the PC restart value
package cpu_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [31:0] IMEM_BASE = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into INST_W-bit words, first byte most significant.
//   clk, rst_n    : clock, synchronous active-low reset
//   clear         : drop any partial word and restart at byte 0
//   shift_en      : a byte transfer happens this cycle
//   byte_in       : byte being transferred
//   word          : shift register contents (a full word after 4 transfers)
//   word_complete : this cycle's transfer is the 4th byte of a word
import cpu_pkg::*;

module byte_packer (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [INST_W-1:0] word,
  output logic              word_complete
);

  logic [INST_W-1:0] shift_q;
  logic [1:0]        byte_cnt_q;

  assign word          = shift_q;
  assign word_complete = shift_en && (byte_cnt_q == 2'd3);

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples its inputs from the same clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else if (clear) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else if (shift_en) begin
      shift_q    <= {shift_q[INST_W-9:0], byte_in};
      // Two-bit counter returns to 0 on its own after the 4th byte.
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory writer: receives a program as a byte stream, packs it
// into 32-bit words and writes them to consecutive addresses from BASE_ADDR,
// holding the CPU while loading and pulsing a PC restart at the end.
//   in_start/in_len        : begin a load of in_len words
//   in_abort               : cancel a load in progress (sets out_err)
//   in_byte_valid/in_byte  : byte source; out_byte_ready accepts it
//   out_imem_wrt/addr/data : instruction-memory write port
//   out_cpu_hold           : freeze PC and pipeline during the load
//   out_pc_reset, out_done : one-cycle pulses when a load completes
//   out_busy               : load in progress
//   out_err                : sticky error (oversize length or abort)
import cpu_pkg::*;

module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = IMEM_BASE,
  parameter int          MAX_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_start,
  input  logic [ADDR_W:0] in_len,
  input  logic            in_abort,
  input  logic            in_byte_valid,
  input  logic [7:0]      in_byte,
  output logic            out_byte_ready,
  output logic            out_imem_wrt,
  output logic [31:0]     out_imem_addr,
  output logic [31:0]     out_imem_data,
  output logic            out_cpu_hold,
  output logic            out_pc_reset,
  output logic            out_busy,
  output logic            out_done,
  output logic            out_err
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_WORDS);

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]   word_cnt_inc;
  logic              err_q, err_d;
  logic              packer_clear;
  logic              shift_en;
  logic              word_complete;
  logic [INST_W-1:0] packed_word;

  assign shift_en     = in_byte_valid && out_byte_ready;
  assign word_cnt_inc = word_cnt_q + (ADDR_W+1)'(1);
  assign out_err      = err_q;

  byte_packer u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (packer_clear),
    .shift_en      (shift_en),
    .byte_in       (in_byte),
    .word          (packed_word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d        = state_q;
    len_d          = len_q;
    word_cnt_d     = word_cnt_q;
    err_d          = err_q;
    packer_clear   = 1'b0;
    out_byte_ready = 1'b0;
    out_imem_wrt   = 1'b0;
    out_imem_addr  = '0;
    out_imem_data  = '0;
    out_cpu_hold   = 1'b0;
    out_pc_reset   = 1'b0;
    out_busy       = 1'b0;
    out_done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_start) begin
          if (in_len == '0) begin
            state_d = DONE;
            err_d   = 1'b0;
          end else if (in_len > MAX_LEN) begin
            err_d = 1'b1;
          end else begin
            state_d      = LOAD;
            len_d        = in_len;
            word_cnt_d   = '0;
            packer_clear = 1'b1;
            err_d        = 1'b0;
          end
        end
      end

      LOAD: begin
        // Abort outranks the handshake: no byte is taken on an abort cycle.
        out_byte_ready = !in_abort;
        out_busy       = 1'b1;
        out_cpu_hold   = 1'b1;
        if (in_abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (word_complete) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        // The write is a Moore output of this state, so it still happens
        // even when an abort arrives in the same cycle.
        out_imem_wrt  = 1'b1;
        out_imem_addr = BASE_ADDR + 32'(word_cnt_q);
        out_imem_data = packed_word;
        out_busy      = 1'b1;
        out_cpu_hold  = 1'b1;
        word_cnt_d    = word_cnt_inc;
        if (in_abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (word_cnt_inc == len_q) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end

      DONE: begin
        out_done     = 1'b1;
        out_pc_reset = 1'b1;
        out_cpu_hold = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader. Stimulus tasks push the
// expected writes and done pulses into a queue; a monitor on the falling
// clock edge pops and compares whenever the DUT writes or signals done.
module tb_imem_loader;

  localparam int          ADDR_W    = 8;
  localparam int          MAX_WORDS = 256;
  localparam logic [31:0] BASE      = 32'h0000_0040;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    bit          is_done;
    bit          after_write;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_start;
  logic [ADDR_W:0] in_len;
  logic            in_abort;
  logic            in_byte_valid;
  logic [7:0]      in_byte;
  logic            out_byte_ready;
  logic            out_imem_wrt;
  logic [31:0]     out_imem_addr;
  logic [31:0]     out_imem_data;
  logic            out_cpu_hold;
  logic            out_pc_reset;
  logic            out_busy;
  logic            out_done;
  logic            out_err;

  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];
  bit  prev_wrt = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_start       (in_start),
    .in_len         (in_len),
    .in_abort       (in_abort),
    .in_byte_valid  (in_byte_valid),
    .in_byte        (in_byte),
    .out_byte_ready (out_byte_ready),
    .out_imem_wrt   (out_imem_wrt),
    .out_imem_addr  (out_imem_addr),
    .out_imem_data  (out_imem_data),
    .out_cpu_hold   (out_cpu_hold),
    .out_pc_reset   (out_pc_reset),
    .out_busy       (out_busy),
    .out_done       (out_done),
    .out_err        (out_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_busy) check("hold_when_busy", 64'(out_cpu_hold), 64'd1);
      if (out_imem_wrt) begin
        check("ready_low_in_write", 64'(out_byte_ready), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("wr_kind", 64'(e.is_done), 64'd0);
          check("wr_addr", 64'(out_imem_addr), 64'(e.addr));
          check("wr_data", 64'(out_imem_data), 64'(e.data));
        end
      end else begin
        if (out_imem_addr !== 32'd0 || out_imem_data !== 32'd0)
          check("idle_addr_data", {out_imem_addr, out_imem_data}, 64'd0);
      end
      if (out_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("done_kind", 64'(e.is_done), 64'd1);
          check("done_latency", 64'(prev_wrt), 64'(e.after_write));
          check("done_pc_reset", 64'(out_pc_reset), 64'd1);
          check("done_hold", 64'(out_cpu_hold), 64'd1);
          check("done_busy", 64'(out_busy), 64'd0);
        end
      end
      prev_wrt = out_imem_wrt;
    end else begin
      prev_wrt = 1'b0;
    end
  end

  // Reference model: word w of the program is bytes 4w..4w+3, first byte MSB.
  task automatic expect_program(input int len, input byte_q_t b, input int words_written,
                                input bit with_done);
    for (int w = 0; w < words_written; w++) begin
      ev_t e;
      e.is_done     = 1'b0;
      e.after_write = 1'b0;
      e.addr        = BASE + 32'(w);
      e.data        = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
      exp_q.push_back(e);
    end
    if (with_done) begin
      ev_t e;
      e.is_done     = 1'b1;
      e.after_write = (len > 0);
      e.addr        = '0;
      e.data        = '0;
      exp_q.push_back(e);
    end
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_start = 1'b0; in_abort = 1'b0; in_byte_valid = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_outs"},
          64'({out_byte_ready, out_imem_wrt, out_cpu_hold, out_pc_reset,
               out_busy, out_done, out_err}), 64'd0);
    check({tag, "_addr_data"}, {out_imem_addr, out_imem_data}, 64'd0);
  endtask

  task automatic do_start(input int len);
    @(posedge clk); #1;
    in_start = 1'b1;
    in_len   = (ADDR_W+1)'(len);
    @(posedge clk); #1;
    in_start = 1'b0;
  endtask

  // mode 0: no bubbles, 1: alternating valid, 2: random bubbles.
  // stray >= 0 raises in_start (len=1) alongside that byte index.
  task automatic send_bytes(input byte_q_t b, input int mode, input int stray);
    for (int i = 0; i < b.size(); i++) begin
      int gaps;
      bit got;
      int budget;
      gaps = (mode == 1) ? ((i > 0) ? 1 : 0) : (mode == 2) ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_byte_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_byte_valid = 1'b1;
      in_byte       = b[i];
      if (i == stray) begin
        in_start = 1'b1;
        in_len   = (ADDR_W+1)'(1);
      end
      got    = 1'b0;
      budget = 0;
      while (!got && budget < 20) begin
        @(negedge clk);
        got = out_byte_ready;
        @(posedge clk); #1;
        in_start = 1'b0;
        budget++;
      end
      if (!got) check("byte_accept_timeout", 64'd1, 64'd0);
    end
    in_byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((out_busy || out_done) && n < 3000);
    if (n >= 3000) check({tag, "_timeout"}, 64'd1, 64'd0);
    check({tag, "_hold_released"}, 64'(out_cpu_hold), 64'd0);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_load(input string tag, input int len, input byte_q_t b,
                          input int mode, input int stray);
    expect_program(len, b, len, 1'b1);
    do_start(len);
    send_bytes(b, mode, stray);
    wait_idle(tag);
    check({tag, "_err"}, 64'(out_err), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t b;
    rst_n = 1'b0; in_start = 1'b0; in_len = '0; in_abort = 1'b0;
    in_byte_valid = 1'b0; in_byte = '0;

    // Reset state
    do_reset();
    check_all_zero("reset");
    release_reset();

    // Basic load with the fixed byte sequence
    b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load("basic", 2, b, 0, -1);

    // Alternating bubbles; the byte offered during WRITE must start word 2
    run_load("bubbles", 2, rand_bytes(8), 1, -1);
    run_load("bubbles_len1", 1, rand_bytes(4), 1, -1);

    // Oversize length: error, stays idle
    do_start(MAX_WORDS + 1);
    @(negedge clk);
    check("oversize_err", 64'(out_err), 64'd1);
    check("oversize_busy", 64'(out_busy), 64'd0);
    check("oversize_ready", 64'(out_byte_ready), 64'd0);
    check("oversize_hold", 64'(out_cpu_hold), 64'd0);

    // Zero length: immediate done, no write, error cleared
    b.delete();
    expect_program(0, b, 0, 1'b1);
    do_start(0);
    @(negedge clk);
    check("len0_done", 64'(out_done), 64'd1);
    check("len0_wrt", 64'(out_imem_wrt), 64'd0);
    check("len0_err", 64'(out_err), 64'd0);
    wait_idle("len0");

    // Full-size program: last write to BASE+MAX_WORDS-1
    run_load("max_len", MAX_WORDS, rand_bytes(4*MAX_WORDS), 0, -1);

    // Abort after 6 bytes of a 3-word load: only the first word lands
    b = rand_bytes(6);
    expect_program(3, b, 1, 1'b0);
    do_start(3);
    send_bytes(b, 0, -1);
    in_abort = 1'b1;
    @(posedge clk); #1;
    in_abort = 1'b0;
    @(negedge clk);
    check("abort_err", 64'(out_err), 64'd1);
    check("abort_busy", 64'(out_busy), 64'd0);
    check("abort_hold", 64'(out_cpu_hold), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_sb_empty", 64'(exp_q.size()), 64'd0);
    run_load("after_abort", 1, rand_bytes(4), 2, -1);

    // Reset mid-load discards the partial word
    do_start(2);
    send_bytes(rand_bytes(2), 0, -1);
    do_reset();
    check_all_zero("midload_reset");
    release_reset();
    run_load("after_reset", 1, rand_bytes(4), 0, -1);

    // in_start during LOAD is ignored; original length still governs
    run_load("stray_start", 2, rand_bytes(8), 0, 2);

    // Random loads
    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(1, 9);
      run_load("random", len, rand_bytes(4*len), $urandom_range(0, 2), -1);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface; the CPU fetch path is the reader side.
- Accepts a program as a byte stream over a valid/ready handshake and packs each 4 bytes into one 32-bit instruction, first byte most significant.
- Writes each packed word into instruction memory at consecutive word addresses starting at BASE_ADDR.
- Holds the CPU pipeline while loading, then pulses a PC restart when the load completes.

Parameters:
- ADDR_W, 8, width of the word-count and word-index counters.
- BASE_ADDR, 0, first instruction-memory address written; also the PC restart value.
- MAX_WORDS, 256, largest accepted program length in words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_start  in  1  one-cycle request to begin a load.
- in_len  in  ADDR_W+1  program length in words, sampled only when in_start is accepted.
- in_abort  in  1  cancels a load in progress.
- in_byte_valid  in  1  source has a byte on in_byte.
- in_byte  in  8  program byte.
- out_byte_ready  out  1  loader accepts in_byte this cycle.
- out_imem_wrt  out  1  instruction-memory write strobe.
- out_imem_addr  out  32  write address, BASE_ADDR + word index.
- out_imem_data  out  32  packed instruction.
- out_cpu_hold  out  1  freezes PC and pipeline buffers.
- out_pc_reset  out  1  one-cycle pulse that forces the PC to BASE_ADDR.
- out_busy  out  1  a load is in progress.
- out_done  out  1  one-cycle pulse when a load completes.
- out_err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State becomes IDLE; byte and word counters are 0; the shift register is 0.
  - All outputs are 0, including out_err.
  - Reset mid-load discards the partial word; no write is issued.
- States: IDLE, LOAD, WRITE, DONE.
- A byte transfer occurs only on a cycle with in_byte_valid=1 and out_byte_ready=1.
- IDLE:
  - out_byte_ready=0.
  - in_start with in_len=0 -> DONE, clears out_err.
  - in_start with in_len>MAX_WORDS -> stays IDLE and sets out_err=1.
  - in_start with any other length -> LOAD; latches len, clears counters and out_err.
- LOAD:
  - out_byte_ready=1; out_busy=1; out_cpu_hold=1.
  - Each transfer shifts the byte into the low 8 bits of the shift register, existing contents moving left; byte_cnt increments.
  - The transfer with byte_cnt=3 moves to WRITE and resets byte_cnt to 0.
  - Bubbles (in_byte_valid=0) are legal at any point and change nothing.
- WRITE (exactly 1 cycle):
  - out_imem_wrt=1; out_imem_addr=BASE_ADDR+word_cnt; out_imem_data=shift register; out_byte_ready=0.
  - word_cnt increments.
  - If the incremented count equals len -> DONE, otherwise -> LOAD.
  - out_imem_addr and out_imem_data are 0 whenever out_imem_wrt=0.
- DONE (exactly 1 cycle):
  - out_done=1; out_pc_reset=1; out_cpu_hold=1; out_busy=0.
  - Next state is IDLE, where out_cpu_hold=0.
- in_start while in LOAD, WRITE or DONE is ignored.
- in_abort in LOAD or WRITE:
  - Next state is IDLE; out_err=1; no DONE pulse.
  - A write already asserted in that same cycle still completes.
  - The partial word is discarded.
  - in_abort in IDLE or DONE has no effect.
- Same-cycle priority: rst_n over in_abort over the handshake.
- Latency:
  - The first write occurs 1 cycle after the 4th byte transfer.
  - out_done is asserted 1 cycle after the last write.
- Minimum throughput is 5 cycles per word.
- word_cnt never wraps, because len ≤ MAX_WORDS ≤ 2^ADDR_W.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding for loader_state_t (IDLE=0, LOAD=1, WRITE=2, DONE=3);
  - INST_W=32;
  - IMEM_BASE, reused by the program counter's reset value.
- Natural sub-module: byte_packer, holding the shift register, byte_cnt and word-complete flag.
- The FSM, word counter and CPU-control outputs stay in imem_loader.

Test Plan:
- Basic load: start with len=2; stream bytes 12 34 56 78 9A BC DE F0 with no bubbles -> writes (BASE+0, 0x12345678), then (BASE+1, 0x9ABCDEF0); out_done and out_pc_reset pulse together 1 cycle after the second write; hold is high throughout and low the cycle after.
- Bubbles and write cycle: len=1, in_byte_valid toggling 1010… -> a single write of the correct word; out_byte_ready=0 on the WRITE cycle, and a byte offered then is not consumed.
- Length boundaries:
  - len=0 -> DONE pulse on the next cycle, with no write.
  - len=MAX_WORDS+1 -> out_err=1, state stays IDLE, out_busy=0.
  - len=MAX_WORDS -> the last write goes to BASE_ADDR+MAX_WORDS-1.
- Abort: abort after 6 bytes of len=3 -> exactly 1 write; state IDLE; out_err=1; no out_done; a following valid start clears out_err.
- Reset mid-load: rst_n=0 after 2 bytes -> all outputs 0 on the next cycle; a new load of len=1 writes its word to BASE_ADDR.
- Ignored start: in_start asserted during LOAD -> len is unchanged; the load completes with the original word count.
